// File: rtl/cache_ctrl_nway_pkg.sv
// Shared definitions for the n-way cache controller: FSM state encoding and
// address-split helpers that work on a zero-extended 64-bit word address.
package cache_config;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_COMPARE    = 2'd1,
        ST_WRITE_BACK = 2'd2,
        ST_ALLOCATE   = 2'd3
    } cache_state_t;

    localparam int unsigned SPLIT_W = 64;

    function automatic logic [SPLIT_W-1:0] addr_field(input logic [SPLIT_W-1:0] addr,
                                                       input int unsigned lsb,
                                                       input int unsigned nbits);
        logic [SPLIT_W-1:0] mask;
        mask = (nbits >= SPLIT_W) ? '1 : ((SPLIT_W'(1) << nbits) - SPLIT_W'(1));
        return (addr >> lsb) & mask;
    endfunction

    function automatic logic [SPLIT_W-1:0] addr_offset(input logic [SPLIT_W-1:0] addr,
                                                        input int unsigned off_bits);
        return addr_field(addr, 0, off_bits);
    endfunction

    function automatic logic [SPLIT_W-1:0] addr_index(input logic [SPLIT_W-1:0] addr,
                                                       input int unsigned off_bits,
                                                       input int unsigned idx_bits);
        return addr_field(addr, off_bits, idx_bits);
    endfunction

    function automatic logic [SPLIT_W-1:0] addr_tag(input logic [SPLIT_W-1:0] addr,
                                                     input int unsigned off_bits,
                                                     input int unsigned idx_bits,
                                                     input int unsigned addr_bits);
        return addr_field(addr, off_bits + idx_bits, addr_bits - off_bits - idx_bits);
    endfunction

    // A direct-mapped cache still needs a 1-bit way select to keep ports legal.
    function automatic int unsigned way_bits(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_lru_tracker.sv
// True-LRU age tracker: one age per way per set, ages form a permutation of
// 0..WAYS-1 and the way holding age WAYS-1 is the victim for the looked-up set.
module cache_lru_tracker
    import cache_config::*;
#(
    parameter int SETS = 16,
    parameter int WAYS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_touch,
    input  logic [$clog2(SETS)-1:0]       i_touch_index,
    input  logic [way_bits(WAYS)-1:0]     i_touch_way,
    input  logic [$clog2(SETS)-1:0]       i_index,
    output logic [way_bits(WAYS)-1:0]     o_victim
);

    localparam int WAY_W = way_bits(WAYS);

    generate
        if (WAYS == 1) begin : g_direct
            assign o_victim = '0;
        end else begin : g_lru
            logic [WAY_W-1:0] r_age [SETS][WAYS];
            logic [WAY_W-1:0] w_old_age;
            logic [WAY_W-1:0] w_victim;

            assign w_old_age = r_age[i_touch_index][i_touch_way];

            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int s = 0; s < SETS; s++) begin
                        for (int w = 0; w < WAYS; w++) begin
                            r_age[s][w] <= WAY_W'(w);
                        end
                    end
                end else if (i_touch) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (WAY_W'(w) == i_touch_way) begin
                            r_age[i_touch_index][w] <= '0;
                        end else if (r_age[i_touch_index][w] < w_old_age) begin
                            r_age[i_touch_index][w] <= r_age[i_touch_index][w] + WAY_W'(1);
                        end
                    end
                end
            end

            always_comb begin
                w_victim = '0;
                for (int w = 0; w < WAYS; w++) begin
                    if (r_age[i_index][w] == WAY_W'(WAYS - 1)) begin
                        w_victim = WAY_W'(w);
                    end
                end
            end

            assign o_victim = w_victim;
        end
    endgenerate

endmodule

// File: rtl/cache_ctrl_nway.sv
// N-way set-associative write-back cache controller with true-LRU replacement
// and a single outstanding line request to the next memory level.
//
//   state         | meaning
//   ST_IDLE       | ready for a request; latches write flag, address, wdata
//   ST_COMPARE    | tag lookup; hit completes, miss picks a victim
//   ST_WRITE_BACK | dirty victim line is being written to memory
//   ST_ALLOCATE   | requested line is being refilled into the victim way
module cache_ctrl_nway
    import cache_config::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int SETS           = 16,
    parameter int WAYS           = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic                                 req_write,
    input  logic [ADDR_WIDTH-1:0]                req_addr,
    input  logic [DATA_WIDTH-1:0]                req_wdata,
    output logic                                 resp_valid,
    output logic [DATA_WIDTH-1:0]                resp_rdata,
    output logic                                 resp_hit,
    output logic                                 mem_req_valid,
    output logic                                 mem_req_write,
    output logic [ADDR_WIDTH-1:0]                mem_req_addr,
    output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] mem_wdata,
    input  logic [WORDS_PER_LINE*DATA_WIDTH-1:0] mem_rdata,
    input  logic                                 mem_ready
);

    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int WAY_W  = way_bits(WAYS);
    localparam int LINE_W = WORDS_PER_LINE * DATA_WIDTH;

    cache_state_t            r_state;
    logic                    r_write;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [WAY_W-1:0]        r_victim;
    logic                    r_refilled;
    logic                    r_resp_valid;
    logic [DATA_WIDTH-1:0]   r_resp_rdata;
    logic                    r_resp_hit;
    logic                    r_mem_req_valid;
    logic                    r_mem_req_write;
    logic [ADDR_WIDTH-1:0]   r_mem_req_addr;
    logic [LINE_W-1:0]       r_mem_wdata;

    logic [TAG_W-1:0]        r_tag   [SETS][WAYS];
    logic [LINE_W-1:0]       r_data  [SETS][WAYS];
    logic                    r_valid [SETS][WAYS];
    logic                    r_dirty [SETS][WAYS];

    logic [SPLIT_W-1:0]      w_addr_ext;
    logic [OFF_W-1:0]        w_offset;
    logic [IDX_W-1:0]        w_index;
    logic [TAG_W-1:0]        w_tag;
    logic                    w_hit;
    logic [WAY_W-1:0]        w_hit_way;
    logic [LINE_W-1:0]       w_hit_line;
    logic [DATA_WIDTH-1:0]   w_hit_word;
    logic [LINE_W-1:0]       w_line_upd;
    logic [WAY_W-1:0]        w_lru_victim;
    logic [WAY_W-1:0]        w_victim;
    logic                    w_found_free;
    logic                    w_cmp_hit;
    logic                    w_wr_hit;
    logic                    w_fill;

    assign w_addr_ext = SPLIT_W'(r_addr);
    assign w_offset   = OFF_W'(addr_offset(w_addr_ext, OFF_W));
    assign w_index    = IDX_W'(addr_index(w_addr_ext, OFF_W, IDX_W));
    assign w_tag      = TAG_W'(addr_tag(w_addr_ext, OFF_W, IDX_W, ADDR_WIDTH));

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_index][w] && (r_tag[w_index][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    assign w_hit_line = r_data[w_index][w_hit_way];
    assign w_hit_word = w_hit_line[int'(w_offset)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        w_line_upd = w_hit_line;
        w_line_upd[int'(w_offset)*DATA_WIDTH +: DATA_WIDTH] = r_wdata;
    end

    // Empty ways are consumed lowest-first before LRU age is consulted.
    always_comb begin
        w_victim     = w_lru_victim;
        w_found_free = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_found_free && !r_valid[w_index][w]) begin
                w_victim     = WAY_W'(w);
                w_found_free = 1'b1;
            end
        end
    end

    assign w_cmp_hit = (r_state == ST_COMPARE) && w_hit;
    assign w_wr_hit  = w_cmp_hit && r_write;
    assign w_fill    = (r_state == ST_ALLOCATE) && r_mem_req_valid && mem_ready;

    cache_lru_tracker #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_lru (
        .clk           (clk),
        .reset         (reset),
        .i_touch       (w_cmp_hit),
        .i_touch_index (w_index),
        .i_touch_way   (w_hit_way),
        .i_index       (w_index),
        .o_victim      (w_lru_victim)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_write         <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_victim        <= '0;
            r_refilled      <= 1'b0;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= '0;
            r_resp_hit      <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_write <= 1'b0;
            r_mem_req_addr  <= '0;
            r_mem_wdata     <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_dirty[s][w] <= 1'b0;
                end
            end
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write    <= req_write;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_refilled <= 1'b0;
                        r_state    <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (w_hit) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_hit_word;
                        r_resp_hit   <= !r_refilled;
                        if (r_write) begin
                            r_dirty[w_index][w_hit_way] <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end else begin
                        r_victim        <= w_victim;
                        r_refilled      <= 1'b1;
                        r_mem_req_valid <= 1'b1;
                        if (r_valid[w_index][w_victim] && r_dirty[w_index][w_victim]) begin
                            r_mem_req_write <= 1'b1;
                            r_mem_req_addr  <= {r_tag[w_index][w_victim], w_index, {OFF_W{1'b0}}};
                            r_mem_wdata     <= r_data[w_index][w_victim];
                            r_state         <= ST_WRITE_BACK;
                        end else begin
                            r_mem_req_write <= 1'b0;
                            r_mem_req_addr  <= {r_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                            r_state         <= ST_ALLOCATE;
                        end
                    end
                end
                ST_WRITE_BACK: begin
                    if (r_mem_req_valid && mem_ready) begin
                        r_dirty[w_index][r_victim] <= 1'b0;
                        r_mem_req_valid            <= 1'b0;
                        r_state                    <= ST_ALLOCATE;
                    end
                end
                ST_ALLOCATE: begin
                    // One idle cycle after a write-back so the refill is a fresh request.
                    if (!r_mem_req_valid) begin
                        r_mem_req_valid <= 1'b1;
                        r_mem_req_write <= 1'b0;
                        r_mem_req_addr  <= {r_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    end else if (mem_ready) begin
                        r_valid[w_index][r_victim] <= 1'b1;
                        r_dirty[w_index][r_victim] <= 1'b0;
                        r_mem_req_valid            <= 1'b0;
                        r_state                    <= ST_COMPARE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (w_wr_hit) begin
                r_data[w_index][w_hit_way] <= w_line_upd;
            end
            if (w_fill) begin
                r_data[w_index][r_victim] <= mem_rdata;
                r_tag[w_index][r_victim]  <= w_tag;
            end
        end
    end

    assign req_ready     = (r_state == ST_IDLE);
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign resp_hit      = r_resp_hit;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_write = r_mem_req_write;
    assign mem_req_addr  = r_mem_req_addr;
    assign mem_wdata     = r_mem_wdata;

endmodule
